// File: rtl/lfsr_rx_checker.sv
// Serial LFSR pattern checker: packs din into 4-bit words (LSB first), compares
// each word against a locally stepped LFSR, and tracks lock plus error count.
module lfsr_rx_checker #(
  parameter int unsigned LOCK_CNT   = 2,
  parameter int unsigned UNLOCK_CNT = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] seed,
  input  logic       load,
  input  logic       din,
  input  logic       din_valid,
  output logic [3:0] word,
  output logic       word_valid,
  output logic       match,
  output logic       locked,
  output logic [7:0] err_cnt
);

  typedef enum logic [1:0] {IDLE, HUNT, LOCKED} state_t;

  state_t     state;
  logic [1:0] bit_cnt;
  logic [3:0] partial;
  logic [3:0] exp;
  logic [7:0] hit_streak;
  logic [7:0] miss_streak;

  logic [3:0] done_word;
  logic       hit;
  logic [3:0] exp_next;

  // The 4th bit is still on din when the word completes, so splice it in here.
  always_comb begin
    done_word = {din, partial[2:0]};
    hit       = (done_word == exp);
    exp_next  = {exp[0] ^ exp[1], exp[3:1]};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      partial     <= '0;
      exp         <= 4'b0001;
      hit_streak  <= '0;
      miss_streak <= '0;
      word        <= '0;
      word_valid  <= 1'b0;
      match       <= 1'b0;
      locked      <= 1'b0;
      err_cnt     <= '0;
    end else begin
      word_valid <= 1'b0;
      if (load) begin
        exp         <= (seed == 4'b0000) ? 4'b0001 : seed;
        bit_cnt     <= '0;
        partial     <= '0;
        err_cnt     <= '0;
        hit_streak  <= '0;
        miss_streak <= '0;
        state       <= HUNT;
        locked      <= 1'b0;
      end else if (din_valid) begin
        if (bit_cnt == 2'd3) begin
          bit_cnt <= '0;
          partial <= '0;
          if (state != IDLE) begin
            word       <= done_word;
            word_valid <= 1'b1;
            match      <= hit;
            exp        <= exp_next;
            if (!hit && err_cnt != 8'hFF)
              err_cnt <= err_cnt + 8'd1;
            case (state)
              HUNT: begin
                if (!hit) begin
                  hit_streak <= '0;
                end else if (hit_streak == 8'(LOCK_CNT - 1)) begin
                  state       <= LOCKED;
                  locked      <= 1'b1;
                  hit_streak  <= '0;
                  miss_streak <= '0;
                end else begin
                  hit_streak <= hit_streak + 8'd1;
                end
              end
              LOCKED: begin
                if (hit) begin
                  miss_streak <= '0;
                end else if (miss_streak == 8'(UNLOCK_CNT - 1)) begin
                  state       <= HUNT;
                  locked      <= 1'b0;
                  miss_streak <= '0;
                  hit_streak  <= '0;
                end else begin
                  miss_streak <= miss_streak + 8'd1;
                end
              end
              default: ;
            endcase
          end
        end else begin
          partial[bit_cnt] <= din;
          bit_cnt          <= bit_cnt + 2'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_lfsr_rx_checker.sv
// Directed bench for lfsr_rx_checker: a behavioural model queues each expected
// word result when its 4th bit is driven; a negedge monitor pops and compares.
module tb_lfsr_rx_checker;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] seed;
  logic       load;
  logic       din;
  logic       din_valid;
  logic [3:0] word;
  logic       word_valid;
  logic       match;
  logic       locked;
  logic [7:0] err_cnt;

  lfsr_rx_checker #(.LOCK_CNT(2), .UNLOCK_CNT(3)) dut (
    .clk(clk), .rst(rst), .seed(seed), .load(load), .din(din),
    .din_valid(din_valid), .word(word), .word_valid(word_valid),
    .match(match), .locked(locked), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] w;
    logic       m;
    logic       l;
    logic [7:0] e;
    int         due;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   wv_seen = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Reference model state
  int         m_state;  // 0 idle, 1 hunt, 2 locked
  logic [3:0] m_exp;
  logic [3:0] m_part;
  int         m_cnt;
  int         m_hit;
  int         m_miss;
  int         m_err;

  function automatic logic [3:0] lfsr_step(input logic [3:0] e);
    return {e[0] ^ e[1], e[3:1]};
  endfunction

  task automatic model_reset();
    m_state = 0; m_exp = 4'b0001; m_part = '0; m_cnt = 0;
    m_hit = 0; m_miss = 0; m_err = 0;
  endtask

  task automatic model_word(input logic [3:0] w);
    exp_t e;
    logic h;
    h = (w == m_exp);
    m_exp = lfsr_step(m_exp);
    if (!h && m_err < 255) m_err++;
    if (m_state == 1) begin
      if (h) begin
        m_hit++;
        if (m_hit == 2) begin m_state = 2; m_hit = 0; m_miss = 0; end
      end else m_hit = 0;
    end else begin
      if (!h) begin
        m_miss++;
        if (m_miss == 3) begin m_state = 1; m_miss = 0; m_hit = 0; end
      end else m_miss = 0;
    end
    e.w = w; e.m = h; e.l = (m_state == 2); e.e = 8'(m_err); e.due = cyc + 1;
    q.push_back(e);
  endtask

  task automatic send_bit(input logic b);
    logic [3:0] w;
    din = b; din_valid = 1'b1;
    if (m_cnt == 3) begin
      w = {b, m_part[2:0]};
      if (m_state != 0) model_word(w);
      m_cnt = 0; m_part = '0;
    end else begin
      m_part[m_cnt] = b;
      m_cnt++;
    end
    @(posedge clk); #1;
    din_valid = 1'b0;
  endtask

  task automatic send_word(input logic [3:0] w);
    for (int i = 0; i < 4; i++) send_bit(w[i]);
  endtask

  task automatic idle(input int n);
    din_valid = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_load(input logic [3:0] s, input logic with_din);
    seed = s; load = 1'b1; din_valid = with_din; din = 1'b1;
    @(posedge clk); #1;
    load = 1'b0; din_valid = 1'b0;
    m_exp = (s == 4'b0000) ? 4'b0001 : s;
    m_cnt = 0; m_part = '0; m_hit = 0; m_miss = 0; m_err = 0; m_state = 1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (word_valid) begin
      wv_seen++;
      chk("wv_expected", 32'(q.size() != 0), 32'd1);
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("wv_cycle", 32'(cyc), 32'(e.due));
        chk("mon_word", 32'(word), 32'(e.w));
        chk("mon_match", 32'(match), 32'(e.m));
        chk("mon_locked", 32'(locked), 32'(e.l));
        chk("mon_err_cnt", 32'(err_cnt), 32'(e.e));
      end
    end else if (q.size() != 0 && q[0].due <= cyc) begin
      e = q.pop_front();
      chk("wv_missing", 32'(word_valid), 32'd1);
    end
  end

  initial begin
    int wv0;
    logic [3:0] w;
    rst = 1'b0; seed = '0; load = 1'b0; din = 1'b0; din_valid = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_word", 32'(word), 32'd0);
    chk("rst_wv", 32'(word_valid), 32'd0);
    chk("rst_match", 32'(match), 32'd0);
    chk("rst_locked", 32'(locked), 32'd0);
    chk("rst_err", 32'(err_cnt), 32'd0);
    rst = 1'b1;

    // Stream without load: block must stay idle
    wv0 = wv_seen;
    for (int i = 0; i < 12; i++) send_bit(1'(i % 3));
    idle(2);
    chk("idle_no_wv", 32'(wv_seen), 32'(wv0));
    chk("idle_err", 32'(err_cnt), 32'd0);
    chk("idle_locked", 32'(locked), 32'd0);

    // Lock on seed 1001
    do_load(4'b1001, 1'b0);
    send_bit(1); send_bit(0); send_bit(0); send_bit(1);
    chk("w1_wv", 32'(word_valid), 32'd1);
    chk("w1_word", 32'(word), 32'h9);
    chk("w1_match", 32'(match), 32'd1);
    chk("w1_locked", 32'(locked), 32'd0);
    idle(1);
    chk("w1_wv_pulse", 32'(word_valid), 32'd0);
    send_bit(0); send_bit(0); send_bit(1); send_bit(1);
    chk("w2_word", 32'(word), 32'hC);
    chk("w2_match", 32'(match), 32'd1);
    chk("w2_locked", 32'(locked), 32'd1);

    // Three mismatches unlock
    send_word(4'b0000);
    chk("m1_locked", 32'(locked), 32'd1);
    send_word(4'b0000);
    chk("m2_locked", 32'(locked), 32'd1);
    send_word(4'b0000);
    chk("m3_match", 32'(match), 32'd0);
    chk("m3_locked", 32'(locked), 32'd0);
    chk("m3_err", 32'(err_cnt), 32'd3);
    w = m_exp;
    send_word(w);
    chk("resync_match", 32'(match), 32'd1);

    // Gaps inside a word
    do_load(4'b1001, 1'b0);
    send_bit(1); idle(1); send_bit(0); send_bit(0); idle(5); send_bit(1);
    chk("gap_wv", 32'(word_valid), 32'd1);
    chk("gap_word", 32'(word), 32'h9);
    chk("gap_match", 32'(match), 32'd1);

    // Load mid-word with din_valid high: partial bits and that bit dropped
    send_bit(1); send_bit(1);
    do_load(4'b0110, 1'b1);
    chk("ld_wv", 32'(word_valid), 32'd0);
    chk("ld_word_kept", 32'(word), 32'h9);
    send_word(4'b0110);
    chk("ld_word", 32'(word), 32'h6);
    chk("ld_match", 32'(match), 32'd1);

    // Asynchronous reset mid-word
    send_bit(1); send_bit(0);
    #2 rst = 1'b0;
    model_reset();
    #1;
    chk("arst_word", 32'(word), 32'd0);
    chk("arst_match", 32'(match), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    wv0 = wv_seen;
    send_word(4'b0001);
    idle(1);
    chk("arst_idle", 32'(wv_seen), 32'(wv0));

    // Zero seed maps to 0001; error counter saturates
    do_load(4'b0000, 1'b0);
    send_bit(1); send_bit(0); send_bit(0); send_bit(0);
    chk("z_word", 32'(word), 32'h1);
    chk("z_match", 32'(match), 32'd1);
    for (int i = 0; i < 300; i++) begin
      w = ~m_exp;
      send_word(w);
    end
    chk("sat_err", 32'(err_cnt), 32'd255);
    chk("sat_match", 32'(match), 32'd0);

    idle(3);
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL timeout: simulation did not finish, errors=%0d", errors);
    $fatal(1, "timeout");
  end

endmodule
